// File: rtl/sha256_msg_sequencer.sv
// Chains pre-padded 512-bit blocks through one sha256_block core and returns the final digest.
// Optional: define SHA256_SEQ_BLKCNT_EN to add the blk_count output (completed-block counter).
module sha256_msg_sequencer #(
    parameter logic [255:0] IHV      = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19,
    parameter logic [7:0]   WATCHDOG = 8'd80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic [255:0] core_H_in,
    output logic [511:0] core_M_in,
    output logic         core_in_valid,
    input  logic [255:0] core_H_out,
    input  logic         core_out_valid,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] dig_data,
    output logic         busy,
    output logic         err_timeout
`ifdef SHA256_SEQ_BLKCNT_EN
    ,
    output logic [31:0]  blk_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [511:0]   msg_q, msg_d;
    logic [255:0]   h_q, h_d;
    logic [255:0]   chain_q, chain_d;
    logic [255:0]   dig_q, dig_d;
    logic           last_q, last_d;
    logic [7:0]     wd_q, wd_d;
    logic           err_q, err_d;
`ifdef SHA256_SEQ_BLKCNT_EN
    logic [31:0]    cnt_q, cnt_d;
`endif

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        h_d     = h_q;
        chain_d = chain_q;
        dig_d   = dig_q;
        last_d  = last_q;
        wd_d    = wd_q;
        err_d   = err_q;
`ifdef SHA256_SEQ_BLKCNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    msg_d   = blk_data;
                    h_d     = blk_first ? IHV : chain_q;
                    last_d  = blk_last;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                wd_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                wd_d = wd_q + 8'd1;
                if (core_out_valid) begin
                    chain_d = core_H_out;
`ifdef SHA256_SEQ_BLKCNT_EN
                    cnt_d   = cnt_q + 32'd1;
`endif
                    // The chain restarts from IHV once a message completes.
                    if (last_q) begin
                        dig_d   = core_H_out;
                        chain_d = IHV;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (wd_q == WATCHDOG - 8'd1) begin
                    err_d   = 1'b1;
                    chain_d = IHV;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (dig_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            msg_q   <= '0;
            h_q     <= '0;
            chain_q <= IHV;
            dig_q   <= '0;
            last_q  <= 1'b0;
            wd_q    <= '0;
            err_q   <= 1'b0;
`ifdef SHA256_SEQ_BLKCNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            h_q     <= h_d;
            chain_q <= chain_d;
            dig_q   <= dig_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
`ifdef SHA256_SEQ_BLKCNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // H_in must stay stable through capture: the core adds it combinationally into H_out.
    assign core_H_in     = h_q;
    assign core_M_in     = msg_q;
    assign core_in_valid = (state_q == S_LOAD);
    assign blk_ready     = (state_q == S_IDLE);
    assign dig_valid     = (state_q == S_DONE);
    assign dig_data      = dig_q;
    assign busy          = (state_q != S_IDLE);
    assign err_timeout   = err_q;
`ifdef SHA256_SEQ_BLKCNT_EN
    assign blk_count     = cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Bench for sha256_msg_sequencer: behavioural SHA-256 core model plus a digest scoreboard.
module tb_sha256_msg_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         blk_first = 1'b0;
    logic         blk_last = 1'b0;
    logic [255:0] core_H_in;
    logic [511:0] core_M_in;
    logic         core_in_valid;
    logic [255:0] core_H_out;
    logic         core_out_valid;
    logic         dig_valid;
    logic         dig_ready = 1'b1;
    logic [255:0] dig_data;
    logic         busy;
    logic         err_timeout;
`ifdef SHA256_SEQ_BLKCNT_EN
    logic [31:0]  blk_count;
`endif

    sha256_msg_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .blk_valid      (blk_valid),
        .blk_ready      (blk_ready),
        .blk_data       (blk_data),
        .blk_first      (blk_first),
        .blk_last       (blk_last),
        .core_H_in      (core_H_in),
        .core_M_in      (core_M_in),
        .core_in_valid  (core_in_valid),
        .core_H_out     (core_H_out),
        .core_out_valid (core_out_valid),
        .dig_valid      (dig_valid),
        .dig_ready      (dig_ready),
        .dig_data       (dig_data),
        .busy           (busy),
        .err_timeout    (err_timeout)
`ifdef SHA256_SEQ_BLKCNT_EN
        ,
        .blk_count      (blk_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural SHA-256 core ----------------
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] m);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e,  hin[95:64] + f,    hin[63:32] + g,    hin[31:0] + h};
    endfunction

    // Core: latches on input_valid, pulses output_valid when its counter reaches 66.
    logic         core_stuck = 1'b0;
    logic         core_busy  = 1'b0;
    logic [6:0]   core_cnt   = '0;
    logic [255:0] core_res   = '0;

    always @(posedge clk) begin
        if (core_in_valid) begin
            core_busy <= 1'b1;
            core_cnt  <= 7'd1;
            core_res  <= sha_compress(core_H_in, core_M_in);
        end else if (core_busy) begin
            core_cnt <= core_cnt + 7'd1;
            if (core_cnt == 7'd66) core_busy <= 1'b0;
        end
    end

    assign core_out_valid = core_busy && (core_cnt == 7'd66) && !core_stuck;
    assign core_H_out     = core_res;

    // ---------------- scoreboard ----------------
    logic [255:0] exp_q [$];
    logic [255:0] exp_dig;

    always @(negedge clk) begin
        if (!rst && dig_valid && dig_ready) begin
            check("dig_expected", 256'(exp_q.size() != 0), 256'd1);
            if (exp_q.size() != 0) begin
                exp_dig = exp_q.pop_front();
                check("dig_data", dig_data, exp_dig);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_block(input logic [511:0] d, input logic f, input logic l, output int acc_cyc);
        int n;
        @(posedge clk); #1;
        blk_valid = 1'b1;
        blk_data  = d;
        blk_first = f;
        blk_last  = l;
        n = 0;
        forever begin
            @(negedge clk);
            if (blk_ready) break;
            n++;
            if (n > 300) begin
                $display("FAIL blk_ready_timeout: actual=0 required=1");
                $fatal(1, "blk_ready never asserted");
            end
        end
        @(posedge clk); #1;
        acc_cyc   = cyc;
        blk_valid = 1'b0;
    endtask

    task automatic wait_dig(output int seen_cyc);
        int n;
        n = 0;
        seen_cyc = -1;
        while (n < 300) begin
            @(negedge clk);
            if (dig_valid) begin
                seen_cyc = cyc;
                break;
            end
            n++;
        end
        check("dig_valid_seen", 256'(seen_cyc >= 0), 256'd1);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    localparam logic [255:0] IHV_C = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic [511:0] blk_abc, blk_two1, blk_two2;
    int           acc, seen;
    logic         flag;
    logic [255:0] held;

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        blk_abc  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        blk_two1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_two2 = {{15{32'h00000000}}, 32'h000001c0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dig_valid", dig_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_timeout, 0);
        check("rst_core_in_valid", core_in_valid, 0);
        check("rst_dig_data", dig_data, 0);
        check("rst_core_H_in", core_H_in, 0);
        check("rst_core_M_in", core_M_in[511:256], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_blk_ready", blk_ready, 1);

        // 1: single-block "abc", 67-cycle latency
        exp_q.push_back(DIG_ABC);
        send_block(blk_abc, 1'b1, 1'b1, acc);
        @(negedge clk);
        check("load_core_H_in", core_H_in, IHV_C);
        check("load_core_M_in", core_M_in, blk_abc);
        wait_dig(seen);
        check("abc_latency", 256'(seen - acc), 256'd67);

        // 2: two-block message, first=0 on block 2 uses the chain
        send_block(blk_two1, 1'b1, 1'b0, acc);
        flag = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dig_valid) flag = 1'b1;
            if (blk_ready) break;
        end
        check("no_dig_after_blk1", flag, 0);
        check("chain_ready_again", blk_ready, 1);
        exp_q.push_back(DIG_TWO);
        send_block(blk_two2, 1'b0, 1'b1, acc);
        wait_dig(seen);

        // 3: back-pressure on the digest
        @(posedge clk); #1;
        dig_ready = 1'b0;
        exp_q.push_back(DIG_ABC);
        send_block(blk_abc, 1'b1, 1'b1, acc);
        wait_dig(seen);
        held = dig_data;
        flag = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!dig_valid || dig_data !== held || blk_ready) flag = 1'b0;
        end
        check("stall_stable", flag, 1);
        check("stall_dig_data", held, DIG_ABC);
        @(posedge clk); #1;
        dig_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_hs_dig_valid", dig_valid, 0);
        check("post_hs_blk_ready", blk_ready, 1);

        // 4: reset in the middle of RUN, then a clean "abc"
        send_block(blk_abc, 1'b1, 1'b1, acc);
        repeat (21) @(negedge clk);
        check("mid_run_busy", busy, 1);
        pulse_rst();
        @(negedge clk);
        check("after_rst_busy", busy, 0);
        check("after_rst_dig_valid", dig_valid, 0);
        flag = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (dig_valid || busy) flag = 1'b1;
        end
        check("no_stale_activity", flag, 0);
        exp_q.push_back(DIG_ABC);
        send_block(blk_abc, 1'b0, 1'b1, acc);
        wait_dig(seen);
        check("after_rst_err", err_timeout, 0);

        // 5: stuck core -> watchdog abort after 80 RUN cycles
        core_stuck = 1'b1;
        send_block(blk_abc, 1'b1, 1'b1, acc);
        while (cyc < acc + 80) @(negedge clk);
        check("wd_err_before", err_timeout, 0);
        check("wd_busy_before", busy, 1);
        @(negedge clk);
        check("wd_err_after", err_timeout, 1);
        check("wd_busy_after", busy, 0);
        core_stuck = 1'b0;
        exp_q.push_back(DIG_ABC);
        send_block(blk_abc, 1'b1, 1'b1, acc);
        wait_dig(seen);
        check("wd_err_sticky", err_timeout, 1);

`ifdef SHA256_SEQ_BLKCNT_EN
        // 6: completed-block counter
        pulse_rst();
        @(negedge clk);
        check("cnt_reset", blk_count, 0);
        exp_q.push_back(DIG_TWO);
        send_block(blk_two1, 1'b1, 1'b0, acc);
        send_block(blk_two2, 1'b0, 1'b1, acc);
        wait_dig(seen);
        exp_q.push_back(DIG_ABC);
        send_block(blk_abc, 1'b1, 1'b1, acc);
        wait_dig(seen);
        @(negedge clk);
        check("cnt_three", blk_count, 3);
        core_stuck = 1'b1;
        send_block(blk_abc, 1'b1, 1'b1, acc);
        while (cyc < acc + 82) @(negedge clk);
        check("cnt_abort_err", err_timeout, 1);
        check("cnt_after_abort", blk_count, 3);
        core_stuck = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 256'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
